// File: rtl/clock_pkg.sv
// Shared mode encodings, BCD field limits and blank masks for the clock_ctrl slice.
// Defining CLOCK_CTRL_12H_EN switches the hour limits to 01..12 with a PM flag.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN    = 2'd0,
    MODE_SET_HH = 2'd1,
    MODE_SET_MM = 2'd2
  } mode_e;

  localparam logic [7:0] SEC_MAX = 8'h59;
  localparam logic [7:0] MIN_MAX = 8'h59;

`ifdef CLOCK_CTRL_12H_EN
  localparam logic [7:0] HR_MAX     = 8'h12;
  localparam logic [7:0] HR_MIN     = 8'h01;
  localparam logic [7:0] HR_RST     = 8'h12;
  // Stepping away from this value (11 -> 12) flips AM/PM.
  localparam logic [7:0] HR_PM_FROM = 8'h11;
`else
  localparam logic [7:0] HR_MAX     = 8'h23;
  localparam logic [7:0] HR_MIN     = 8'h00;
  localparam logic [7:0] HR_RST     = 8'h00;
`endif

  // digit_blank bit order is {hh_t, hh_u, mm_t, mm_u, ss_t, ss_u}
  localparam int unsigned BLANK_HH_T = 5;
  localparam int unsigned BLANK_HH_U = 4;
  localparam int unsigned BLANK_MM_T = 3;
  localparam int unsigned BLANK_MM_U = 2;

  localparam logic [5:0] BLANK_HH_MASK = 6'((1 << BLANK_HH_T) | (1 << BLANK_HH_U));
  localparam logic [5:0] BLANK_MM_MASK = 6'((1 << BLANK_MM_T) | (1 << BLANK_MM_U));

endpackage

// File: rtl/clock_ctrl_bcd2_counter.sv
// Two-digit BCD counter wrapping MAX -> MIN, with clear, parallel load and a wrap carry.
// Units never pass 9; clear has priority over load, load over increment.
module bcd2_counter #(
  parameter logic [7:0] MAX = 8'h59,
  parameter logic [7:0] MIN = 8'h00,
  parameter logic [7:0] RST = 8'h00
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       inc,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic       carry
);

  logic [7:0] value_d;
  logic [7:0] value_q;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = MIN;
    end else if (load) begin
      value_d = load_val;
    end else if (inc) begin
      if (value_q == MAX) begin
        value_d = MIN;
      end else if (value_q[3:0] == 4'd9) begin
        value_d = {value_q[7:4] + 4'd1, 4'd0};
      end else begin
        value_d = {value_q[7:4], value_q[3:0] + 4'd1};
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= RST;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign carry = inc & ~clr & ~load & (value_q == MAX);

endmodule

// File: rtl/clock_ctrl.sv
// Timekeeping and time-set controller: BCD hh:mm:ss, mode/adjust FSM with auto-repeat, set-mode blink.
// Build option CLOCK_CTRL_12H_EN selects 12 h operation with a PM indicator (24 h otherwise).
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = 3
) (
  input  logic       clk_in,
  input  logic       reset_n,
  input  logic       tick_1hz,
  input  logic       tick_5hz,
  input  logic       btn_mode,
  input  logic       btn_adj,
  output logic [7:0] hours,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic [1:0] mode,
  output logic [5:0] digit_blank,
  output logic       pm
);

  localparam logic [3:0] REP_LIMIT = 4'(REPEAT_DELAY);

  logic       tick_1hz_q;
  logic       tick_5hz_q;
  logic       btn_mode_q;
  logic       btn_adj_q;
  logic       sec_stb;
  logic       rep_stb;
  logic       mode_stb;
  logic       adj_stb;
  mode_e      state_q;
  logic       in_run;
  logic [3:0] rep_cnt_d;
  logic [3:0] rep_cnt_q;
  logic       rep_fire;
  logic       step;
  logic       sec_inc;
  logic       sec_clr;
  logic       sec_carry;
  logic       min_inc;
  logic       min_carry;
  logic       hr_inc;
  logic       hr_carry_unused;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      tick_1hz_q <= 1'b0;
      tick_5hz_q <= 1'b0;
      btn_mode_q <= 1'b0;
      btn_adj_q  <= 1'b0;
    end else begin
      tick_1hz_q <= tick_1hz;
      tick_5hz_q <= tick_5hz;
      btn_mode_q <= btn_mode;
      btn_adj_q  <= btn_adj;
    end
  end

  assign sec_stb  = tick_1hz & ~tick_1hz_q;
  assign rep_stb  = tick_5hz & ~tick_5hz_q;
  assign mode_stb = btn_mode & ~btn_mode_q;
  assign adj_stb  = btn_adj & ~btn_adj_q;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MODE_RUN;
    end else if (mode_stb) begin
      case (state_q)
        MODE_RUN:    state_q <= MODE_SET_HH;
        MODE_SET_HH: state_q <= MODE_SET_MM;
        default:     state_q <= MODE_RUN;
      endcase
    end
  end

  assign in_run = (state_q == MODE_RUN);
  assign mode   = state_q;

  // Auto-repeat: the first REP_LIMIT 5 Hz strobes of a hold only count, later ones step.
  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_fire  = 1'b0;
    if (in_run || mode_stb || !btn_adj) begin
      rep_cnt_d = 4'd0;
    end else if (rep_stb) begin
      if (rep_cnt_q == REP_LIMIT) begin
        rep_fire = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      rep_cnt_q <= 4'd0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end

  assign step = ~in_run & ~mode_stb & (adj_stb | rep_fire);

  // A mode press in RUN wins over a coincident tick and clears the seconds.
  assign sec_inc = in_run & sec_stb & ~mode_stb;
  assign sec_clr = in_run & mode_stb;
  assign min_inc = (in_run & sec_carry) | ((state_q == MODE_SET_MM) & step);
  assign hr_inc  = (in_run & min_carry) | ((state_q == MODE_SET_HH) & step);

  bcd2_counter #(
    .MAX (SEC_MAX),
    .MIN (8'h00),
    .RST (8'h00)
  ) u_seconds (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .inc      (sec_inc),
    .clr      (sec_clr),
    .load     (1'b0),
    .load_val (8'h00),
    .value    (seconds),
    .carry    (sec_carry)
  );

  bcd2_counter #(
    .MAX (MIN_MAX),
    .MIN (8'h00),
    .RST (8'h00)
  ) u_minutes (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .inc      (min_inc),
    .clr      (1'b0),
    .load     (1'b0),
    .load_val (8'h00),
    .value    (minutes),
    .carry    (min_carry)
  );

  bcd2_counter #(
    .MAX (HR_MAX),
    .MIN (HR_MIN),
    .RST (HR_RST)
  ) u_hours (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .inc      (hr_inc),
    .clr      (1'b0),
    .load     (1'b0),
    .load_val (8'h00),
    .value    (hours),
    .carry    (hr_carry_unused)
  );

`ifdef CLOCK_CTRL_12H_EN
  logic pm_d;
  logic pm_q;

  always_comb begin
    pm_d = pm_q;
    if (hr_inc && (hours == HR_PM_FROM)) begin
      pm_d = ~pm_q;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      pm_q <= 1'b0;
    end else begin
      pm_q <= pm_d;
    end
  end

  assign pm = pm_q;
`else
  assign pm = 1'b0;
`endif

  // Blink the field being set while the 1 Hz wave is low, held solid while adj is down.
  always_comb begin
    digit_blank = 6'b000000;
    if (!tick_1hz && !btn_adj) begin
      if (state_q == MODE_SET_HH) begin
        digit_blank = BLANK_HH_MASK;
      end else if (state_q == MODE_SET_MM) begin
        digit_blank = BLANK_MM_MASK;
      end
    end
  end

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl: directed scenarios plus randomized inputs against a
// time-of-day reference model (hour kept as 0..23, display derived for 12 h or 24 h builds).
module tb_clock_ctrl;

  localparam int RD = 3;

`ifdef CLOCK_CTRL_12H_EN
  localparam logic [7:0] MIDNIGHT_HR = 8'h12;
  localparam logic       NOON_PM     = 1'b1;
`else
  localparam logic [7:0] MIDNIGHT_HR = 8'h00;
  localparam logic       NOON_PM     = 1'b0;
`endif

  logic       clk_in = 1'b0;
  logic       reset_n;
  logic       t1;
  logic       t5;
  logic       bm;
  logic       ba;
  logic [7:0] hours;
  logic [7:0] minutes;
  logic [7:0] seconds;
  logic [1:0] mode;
  logic [5:0] digit_blank;
  logic       pm;

  int checks = 0;
  int errors = 0;

  int h, m, s, md, reps;
  bit p1, p5, pb, pa;

  always #5 clk_in = ~clk_in;

  clock_ctrl #(.REPEAT_DELAY(RD)) dut (
    .clk_in      (clk_in),
    .reset_n     (reset_n),
    .tick_1hz    (t1),
    .tick_5hz    (t5),
    .btn_mode    (bm),
    .btn_adj     (ba),
    .hours       (hours),
    .minutes     (minutes),
    .seconds     (seconds),
    .mode        (mode),
    .digit_blank (digit_blank),
    .pm          (pm)
  );

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [32:0] obs();
    return {hours, minutes, seconds, mode, digit_blank, pm};
  endfunction

  function automatic logic [32:0] exp_vec();
    logic [7:0] hd;
    logic       pmv;
    logic [5:0] bl;
`ifdef CLOCK_CTRL_12H_EN
    hd  = bcd((h % 12 == 0) ? 12 : h % 12);
    pmv = (h >= 12);
`else
    hd  = bcd(h);
    pmv = 1'b0;
`endif
    bl = 6'b000000;
    if (!t1 && !ba) begin
      if (md == 1) bl = 6'b110000;
      else if (md == 2) bl = 6'b001100;
    end
    return {hd, bcd(m), bcd(s), 2'(md), bl, pmv};
  endfunction

  task automatic model_reset();
    h = 0; m = 0; s = 0; md = 0; reps = 0;
    p1 = 0; p5 = 0; pb = 0; pa = 0;
  endtask

  // One clock of the reference: time as seconds-of-day, repeat as strobes seen since the hold began.
  task automatic model_clock();
    bit sec, rep, ms, as, stp;
    int tot;
    sec = t1 && !p1;
    rep = t5 && !p5;
    ms  = bm && !pb;
    as  = ba && !pa;
    if (ms) begin
      if (md == 0) s = 0;
      md   = (md + 1) % 3;
      reps = 0;
    end else if (md == 0) begin
      reps = 0;
      if (sec) begin
        tot = (h * 3600 + m * 60 + s + 1) % 86400;
        h = tot / 3600;
        m = (tot / 60) % 60;
        s = tot % 60;
      end
    end else begin
      stp = as;
      if (!ba) begin
        reps = 0;
      end else if (rep) begin
        if (reps >= RD) stp = 1;
        reps++;
      end
      if (stp) begin
        if (md == 1) h = (h + 1) % 24;
        else m = (m + 1) % 60;
      end
    end
    p1 = t1; p5 = t5; pb = bm; pa = ba;
  endtask

  task automatic cyc(input logic a, input logic b, input logic c, input logic d);
    @(negedge clk_in);
    t1 = a; t5 = b; bm = c; ba = d;
    @(posedge clk_in);
    model_clock();
    #1;
  endtask

  task automatic press_mode();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_adj();
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Starting in RUN, walk the set modes to reach th:tm (th as 0..23), then run ts seconds.
  task automatic goto_time(input int th, input int tm, input int ts);
    press_mode();
    repeat ((th - h + 24) % 24) press_adj();
    press_mode();
    repeat ((tm - m + 60) % 60) press_adj();
    press_mode();
    repeat (ts) tick();
  endtask

  applyStimulusDummy_unused_guard: assert property (@(posedge clk_in) 1'b1);

  task automatic test_reset();
    reset_n = 1'b0; t1 = 0; t5 = 0; bm = 0; ba = 0;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    checks++;
    if (obs() !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL reset_init: actual %h required %h", obs(), exp_vec());
    end
    @(negedge clk_in);
    reset_n = 1'b1;
    goto_time(23, 59, 58);
    checks++;
    if (obs() !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL preset_235958: actual %h required %h", obs(), exp_vec());
    end
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs() !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL async_reset: actual %h required %h", obs(), exp_vec());
    end
    @(negedge clk_in);
    reset_n = 1'b1;
  endtask

  task automatic test_rollover();
    goto_time(23, 59, 58);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs() !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL roll_235959: actual %h required %h", obs(), exp_vec());
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs() !== exp_vec() || {hours, minutes, seconds} !== {MIDNIGHT_HR, 16'h0000}) begin
      errors++;
      $display("[TB] FAIL roll_midnight: actual %h required %h", obs(), exp_vec());
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_set_blink();
    tick();
    tick();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs() !== exp_vec() || mode !== 2'd1 || seconds !== 8'h00 || digit_blank !== 6'b110000) begin
      errors++;
      $display("[TB] FAIL set_hh_blank_low: actual %h required %h", obs(), exp_vec());
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs() !== exp_vec() || digit_blank !== 6'b000000) begin
      errors++;
      $display("[TB] FAIL set_hh_blank_high: actual %h required %h", obs(), exp_vec());
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs() !== exp_vec()) begin
      errors++;
      $display("[TB] FAIL set_hh_adj_held: actual %h required %h", obs(), exp_vec());
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    press_mode();
    checks++;
    if (obs() !== exp_vec() || digit_blank !== 6'b001100) begin
      errors++;
      $display("[TB] FAIL set_mm_blank: actual %h required %h", obs(), exp_vec());
    end
    press_mode();
  endtask

  task automatic test_repeat();
    press_mode();
    press_mode();
    repeat ((58 - m + 60) % 60) press_adj();
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs() !== exp_vec() || minutes !== 8'h59) begin
      errors++;
      $display("[TB] FAIL repeat_first_step: actual %h required %h", obs(), exp_vec());
    end
    for (int k = 1; k <= RD + 2; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL repeat_strobe_%0d: actual %h required %h", k, obs(), exp_vec());
      end
    end
    checks++;
    if (minutes !== 8'h01) begin
      errors++;
      $display("[TB] FAIL repeat_final: actual %h required %h", minutes, 8'h01);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    press_mode();
  endtask

  task automatic test_simultaneous();
    press_mode();
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (obs() !== exp_vec() || mode !== 2'd2) begin
      errors++;
      $display("[TB] FAIL mode_beats_adj: actual %h required %h", obs(), exp_vec());
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    press_mode();
    tick();
    checks++;
    if (obs() !== exp_vec() || seconds !== 8'h01 || mode !== 2'd0) begin
      errors++;
      $display("[TB] FAIL resume_from_00: actual %h required %h", obs(), exp_vec());
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs() !== exp_vec() || seconds !== 8'h00 || mode !== 2'd1) begin
      errors++;
      $display("[TB] FAIL mode_beats_tick: actual %h required %h", obs(), exp_vec());
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    press_mode();
    press_mode();
  endtask

  task automatic test_hour_carry();
    goto_time(11, 59, 59);
    tick();
    checks++;
    if (obs() !== exp_vec() || {hours, minutes, seconds, pm} !== {8'h12, 16'h0000, NOON_PM}) begin
      errors++;
      $display("[TB] FAIL noon_carry: actual %h required %h", obs(), exp_vec());
    end
  endtask

  task automatic test_random();
    logic a, b, c, d;
    for (int i = 0; i < 800; i++) begin
      a = t1 ^ ($urandom_range(3) == 0);
      b = t5 ^ ($urandom_range(2) == 0);
      c = bm ^ ($urandom_range(15) == 0);
      d = ba ^ ($urandom_range(5) == 0);
      cyc(a, b, c, d);
      checks++;
      if (obs() !== exp_vec()) begin
        errors++;
        $display("[TB] FAIL random_%0d: actual %h required %h", i, obs(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_set_blink();
    test_repeat();
    test_simultaneous();
    test_hour_carry();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
